// File: rtl/m_stage_mc.sv
// Y86 memory-access stage driving a multi-cycle data memory over a req/ack handshake.
// Stalls the pipeline while a transaction is pending and reports faults as ADR status.
module m_stage_mc #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int ALIGN_CHECK = 1,
    parameter int TIMEOUT     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M_valid_i,
    input  logic [3:0]        M_icode_i,
    input  logic [DATA_W-1:0] M_valA_i,
    input  logic [DATA_W-1:0] M_valP_i,
    input  logic [DATA_W-1:0] M_valE_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_err_i,
    output logic              m_stall_o,
    output logic [DATA_W-1:0] m_valM_o,
    output logic              m_done_o,
    output logic [1:0]        m_stat_o
);
    localparam int AL_BITS = $clog2(DATA_W / 8);
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] STAT_AOK = 2'b00;
    localparam logic [1:0] STAT_ADR = 2'b10;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q;
    logic              req_q, we_q, done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, valm_q;
    logic [1:0]        stat_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              is_rd, is_wr, op_live, misaligned, timeout_hit;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;

    always_comb begin
        is_rd    = 1'b0;
        is_wr    = 1'b0;
        op_addr  = M_valE_i[ADDR_W-1:0];
        op_wdata = M_valA_i;
        case (M_icode_i)
            4'h4, 4'hA: is_wr = 1'b1;
            4'h8: begin
                is_wr    = 1'b1;
                op_wdata = M_valP_i;
            end
            4'h5: is_rd = 1'b1;
            4'h9, 4'hB: begin
                is_rd   = 1'b1;
                op_addr = M_valA_i[ADDR_W-1:0];
            end
            default: ;
        endcase
    end

    assign op_live     = M_valid_i & (is_rd | is_wr);
    assign misaligned  = (ALIGN_CHECK != 0) && (op_addr[AL_BITS-1:0] != '0);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Gated by reset so the stall falls immediately on an asynchronous reset.
    always_comb begin
        m_stall_o = 1'b0;
        if (rst) begin
            if (state_q == IDLE) m_stall_o = op_live & ~misaligned;
            else                 m_stall_o = ~mem_ack_i & ~timeout_hit;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            valm_q  <= '0;
            stat_q  <= STAT_AOK;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (op_live) begin
                        if (misaligned) begin
                            stat_q <= STAT_ADR;
                            done_q <= 1'b1;
                        end else begin
                            state_q <= BUSY;
                            req_q   <= 1'b1;
                            we_q    <= is_wr;
                            addr_q  <= op_addr;
                            wdata_q <= op_wdata;
                            cnt_q   <= '0;
                        end
                    end
                end
                BUSY: begin
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (mem_ack_i) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        if (mem_err_i) begin
                            stat_q <= STAT_ADR;
                        end else begin
                            stat_q <= STAT_AOK;
                            if (!we_q) valm_q <= mem_rdata_i;
                        end
                    end else if (timeout_hit) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        stat_q  <= STAT_ADR;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign m_valM_o    = valm_q;
    assign m_done_o    = done_q;
    assign m_stat_o    = stat_q;
endmodule

// File: tb/tb_m_stage_mc.sv
// Directed bench for m_stage_mc: read, write, misalign, timeout, bus error, back-to-back, async reset.
module tb_m_stage_mc;
    localparam logic [1:0] AOK = 2'b00;
    localparam logic [1:0] ADR = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        M_valid_i = 1'b0;
    logic [3:0]  M_icode_i = 4'h0;
    logic [31:0] M_valA_i = '0, M_valP_i = '0, M_valE_i = '0;
    logic        mem_ack_i = 1'b0, mem_err_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    logic        req, we, stall, done;
    logic [31:0] addr, wdata, valm;
    logic [1:0]  stat;
    logic        req2, we2, stall2, done2;
    logic [31:0] addr2, wdata2, valm2;
    logic [1:0]  stat2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m_stage_mc #(.DATA_W(32), .ADDR_W(32), .ALIGN_CHECK(1), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .M_valid_i(M_valid_i), .M_icode_i(M_icode_i),
        .M_valA_i(M_valA_i), .M_valP_i(M_valP_i), .M_valE_i(M_valE_i),
        .mem_req_o(req), .mem_we_o(we), .mem_addr_o(addr), .mem_wdata_o(wdata),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .m_stall_o(stall), .m_valM_o(valm), .m_done_o(done), .m_stat_o(stat));

    m_stage_mc #(.DATA_W(32), .ADDR_W(32), .ALIGN_CHECK(0), .TIMEOUT(16)) dut_noalign (
        .clk(clk), .rst(rst), .M_valid_i(M_valid_i), .M_icode_i(M_icode_i),
        .M_valA_i(M_valA_i), .M_valP_i(M_valP_i), .M_valE_i(M_valE_i),
        .mem_req_o(req2), .mem_we_o(we2), .mem_addr_o(addr2), .mem_wdata_o(wdata2),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .m_stall_o(stall2), .m_valM_o(valm2), .m_done_o(done2), .m_stat_o(stat2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [3:0] ic, input logic [31:0] va, input logic [31:0] vp, input logic [31:0] ve);
        M_valid_i = 1'b1; M_icode_i = ic; M_valA_i = va; M_valP_i = vp; M_valE_i = ve;
        #1;
    endtask

    task automatic test_reset();
        step(); step();
        checks++; if (req !== 1'b0)   begin errors++; $display("FAIL rst_req got %b exp 0", req); end
        checks++; if (we !== 1'b0)    begin errors++; $display("FAIL rst_we got %b exp 0", we); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", stall); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rst_done got %b exp 0", done); end
        checks++; if (addr !== 32'h0 || wdata !== 32'h0 || valm !== 32'h0) begin errors++; $display("FAIL rst_data got %h/%h/%h exp 0", addr, wdata, valm); end
        checks++; if (stat !== AOK)   begin errors++; $display("FAIL rst_stat got %b exp %b", stat, AOK); end
        rst = 1'b1;
        step();
        $display("reset released");
    endtask

    task automatic test_read_ok();
        present(4'h5, 32'h0, 32'h0, 32'h100);
        checks++; if (stall !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL rd_issue stall/req got %b/%b exp 1/0", stall, req); end
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #1; end
            checks++; if (req !== 1'b1 || we !== 1'b0 || addr !== 32'h100) begin errors++; $display("FAIL rd_busy%0d req/we/addr got %b/%b/%h exp 1/0/100", i, req, we, addr); end
            checks++; if (stall !== (i != 2)) begin errors++; $display("FAIL rd_stall%0d got %b exp %b", i, stall, (i != 2)); end
            step();
        end
        mem_ack_i = 1'b0; M_valid_i = 1'b0;
        checks++; if (valm !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_valm got %h exp deadbeef", valm); end
        checks++; if (stat !== AOK || done !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL rd_done stat/done/req got %b/%b/%b exp 00/1/0", stat, done, req); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rd_done_pulse got %b exp 0", done); end
        $display("read ok: addr 0x100 -> 0xdeadbeef");
    endtask

    task automatic test_write_call();
        present(4'h8, 32'h55, 32'h24, 32'h1FC);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL call_issue_stall got %b exp 1", stall); end
        step();
        checks++; if (req !== 1'b1 || we !== 1'b1 || addr !== 32'h1FC || wdata !== 32'h24) begin errors++; $display("FAIL call_busy req/we/addr/wdata got %b/%b/%h/%h exp 1/1/1fc/24", req, we, addr, wdata); end
        mem_ack_i = 1'b1; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL call_ack_stall got %b exp 0", stall); end
        step();
        mem_ack_i = 1'b0; M_valid_i = 1'b0;
        checks++; if (req !== 1'b0 || done !== 1'b1 || stat !== AOK) begin errors++; $display("FAIL call_done req/done/stat got %b/%b/%b exp 0/1/00", req, done, stat); end
        checks++; if (valm !== 32'hDEADBEEF) begin errors++; $display("FAIL call_valm got %h exp deadbeef", valm); end
        step();
        $display("write call: addr 0x1fc data 0x24");
    endtask

    task automatic test_misaligned();
        present(4'hA, 32'h77, 32'h0, 32'h102);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %b exp 0", stall); end
        checks++; if (stall2 !== 1'b1) begin errors++; $display("FAIL mis_noalign_stall got %b exp 1", stall2); end
        step();
        M_valid_i = 1'b0;
        checks++; if (req !== 1'b0 || done !== 1'b1 || stat !== ADR) begin errors++; $display("FAIL mis_fault req/done/stat got %b/%b/%b exp 0/1/10", req, done, stat); end
        checks++; if (req2 !== 1'b1 || addr2 !== 32'h102 || we2 !== 1'b1) begin errors++; $display("FAIL mis_noalign_req req/addr/we got %b/%h/%b exp 1/102/1", req2, addr2, we2); end
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        checks++; if (done2 !== 1'b1 || stat2 !== AOK) begin errors++; $display("FAIL mis_noalign_done done/stat got %b/%b exp 1/00", done2, stat2); end
        checks++; if (done !== 1'b0 || stat !== ADR || req !== 1'b0) begin errors++; $display("FAIL mis_idle_ack done/stat/req got %b/%b/%b exp 0/10/0", done, stat, req); end
        step();
        $display("misaligned push: addr 0x102 -> ADR");
    endtask

    task automatic test_timeout();
        present(4'hB, 32'h200, 32'h0, 32'h999);
        step();
        for (int i = 0; i < 16; i++) begin
            checks++; if (req !== 1'b1 || addr !== 32'h200) begin errors++; $display("FAIL to_busy%0d req/addr got %b/%h exp 1/200", i, req, addr); end
            checks++; if (stall !== (i != 15)) begin errors++; $display("FAIL to_stall%0d got %b exp %b", i, stall, (i != 15)); end
            step();
        end
        M_valid_i = 1'b0;
        checks++; if (req !== 1'b0 || done !== 1'b1 || stat !== ADR) begin errors++; $display("FAIL to_fault req/done/stat got %b/%b/%b exp 0/1/10", req, done, stat); end
        mem_ack_i = 1'b1;
        step();
        mem_ack_i = 1'b0;
        checks++; if (done !== 1'b0 || stat !== ADR) begin errors++; $display("FAIL to_late_ack done/stat got %b/%b exp 0/10", done, stat); end
        $display("timeout pop: addr 0x200 -> ADR after 16 cycles");
    endtask

    task automatic test_bus_error();
        present(4'h5, 32'h0, 32'h0, 32'h300);
        step(); step();
        mem_ack_i = 1'b1; mem_err_i = 1'b1; mem_rdata_i = 32'h12345678;
        step();
        mem_ack_i = 1'b0; mem_err_i = 1'b0; M_valid_i = 1'b0;
        checks++; if (stat !== ADR || done !== 1'b1 || req !== 1'b0) begin errors++; $display("FAIL err_fault stat/done/req got %b/%b/%b exp 10/1/0", stat, done, req); end
        checks++; if (valm !== 32'hDEADBEEF) begin errors++; $display("FAIL err_valm got %h exp deadbeef", valm); end
        step();
        $display("bus error read: addr 0x300 -> ADR");
    endtask

    task automatic test_back_to_back();
        present(4'h4, 32'h11, 32'h0, 32'h40);
        step();
        checks++; if (req !== 1'b1 || we !== 1'b1 || addr !== 32'h40 || wdata !== 32'h11) begin errors++; $display("FAIL b2b_wr req/we/addr/wdata got %b/%b/%h/%h exp 1/1/40/11", req, we, addr, wdata); end
        mem_ack_i = 1'b1;
        step();
        checks++; if (done !== 1'b1 || stat !== AOK) begin errors++; $display("FAIL b2b_wr_done done/stat got %b/%b exp 1/00", done, stat); end
        mem_ack_i = 1'b0;
        present(4'h9, 32'h80, 32'h0, 32'hAAA);
        checks++; if (req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL b2b_gap req/stall got %b/%b exp 0/1", req, stall); end
        step();
        checks++; if (req !== 1'b1 || we !== 1'b0 || addr !== 32'h80) begin errors++; $display("FAIL b2b_ret req/we/addr got %b/%b/%h exp 1/0/80", req, we, addr); end
        mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE0001;
        step();
        mem_ack_i = 1'b0;
        checks++; if (valm !== 32'hCAFE0001 || done !== 1'b1) begin errors++; $display("FAIL b2b_ret_done valm/done got %h/%b exp cafe0001/1", valm, done); end
        present(4'h6, 32'h80, 32'h0, 32'h80);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL noop_stall got %b exp 0", stall); end
        step();
        checks++; if (req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL noop_req req/done got %b/%b exp 0/0", req, done); end
        M_valid_i = 1'b0; M_icode_i = 4'h5; M_valE_i = 32'h100; #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL bubble_stall got %b exp 0", stall); end
        step();
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL bubble_req got %b exp 0", req); end
        $display("back to back: rmmovl, ret, nop, bubble");
    endtask

    task automatic test_async_reset();
        present(4'h5, 32'h0, 32'h0, 32'h500);
        step();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL ar_busy req got %b exp 1", req); end
        #2 rst = 1'b0;
        #1;
        checks++; if (req !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL ar_drop req/stall got %b/%b exp 0/0", req, stall); end
        M_valid_i = 1'b0;
        #1 rst = 1'b1;
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        step();
        mem_ack_i = 1'b0;
        checks++; if (stat !== AOK || done !== 1'b0 || valm !== 32'h0 || req !== 1'b0) begin errors++; $display("FAIL ar_late_ack stat/done/valm/req got %b/%b/%h/%b exp 00/0/0/0", stat, done, valm, req); end
        $display("async reset in busy: request dropped");
    endtask

    initial begin
        test_reset();
        test_read_ok();
        test_write_call();
        test_misaligned();
        test_timeout();
        test_bus_error();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
